axi_cfg_regfile: RTL and testbench
==================================

Name: axi_cfg_regfile

Overview:
- Parametrised AXI4-Lite slave register file; successor to the fixed 4-register config block in the SNN accelerator top level.
- Provides N generic RW config registers with byte strobes and a start pulse with status bits.
- Adds a read-only spike-counter bank and an external memory window with a pulsed write enable and registered read.
- Read and write channels are independent; bad accesses return SLVERR.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; fixed at 32.
- C_S_AXI_ADDR_WIDTH, 12, byte address width; minimum 12.
- NUM_CFG_REGS, 4, RW registers at 0x000+4*i (1..256).
- NUM_OUTPUTS, 10, read-only spike counters at 0x400+4*i (1..256).
- SIM_TIME_RESET, 100, reset value of cfg reg 1.

Ports:
- S_AXI_ACLK, in, 1, clock.
- S_AXI_ARESETN, in, 1, reset; synchronous, active-low.
- S_AXI_AWADDR / S_AXI_AWVALID / S_AXI_AWREADY, in/in/out, ADDR/1/1, write address channel.
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID / S_AXI_WREADY, in/in/in/out, 32/4/1/1, write data channel.
- S_AXI_BRESP / S_AXI_BVALID / S_AXI_BREADY, out/out/in, 2/1/1, write response channel.
- S_AXI_ARADDR / S_AXI_ARVALID / S_AXI_ARREADY, in/in/out, ADDR/1/1, read address channel.
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID / S_AXI_RREADY, out/out/out/in, 32/2/1/1, read data channel.
- spike_counter_out, in, 32 x NUM_OUTPUTS, counter values.
- done, in, 1, network status.
- network_busy, in, 1, network status.
- ext_mem_data_out, in, 32, external memory read data; valid 1 cycle after address.
- cfg_regs, out, 32*NUM_CFG_REGS, flattened register contents; reg 0 in bits [31:0].
- start_pulse, out, 1, one-cycle pulse on a write of 1 to reg0 bit0.
- ext_mem_addr, out, 32, {cfg reg2[31:8], window offset[9:2]}.
- ext_mem_wen, out, 1, external memory write enable.
- ext_mem_data_in, out, 32, external memory write data.

Behaviour:
- Reset (ARESETN low at clock edge): all READY/VALID low, RESP 0, RDATA 0, ext_mem_wen 0, start_pulse 0; cfg regs 0 except reg1 = SIM_TIME_RESET.
- Address decode on ADDR[11:0], word aligned; ADDR[1:0] ignored:
  - cfg region: 0x000..0x3FF; index < NUM_CFG_REGS, else unmapped.
  - counter region: 0x400..0x7FF; index < NUM_OUTPUTS, else unmapped.
  - memory window: 0x800..0xBFF.
  - 0xC00..0xFFF: unmapped.
- Write FSM, states W_IDLE, W_RESP:
  - AWREADY high while no AW is latched and BVALID is low; WREADY likewise for W.
  - AW and W may arrive in either order or together.
  - The cycle after both are latched, the write is performed and FSM enters W_RESP with BVALID=1.
  - BVALID holds until BREADY, then returns to W_IDLE. Back-to-back writes run at most 1 every 2 cycles.
- Write effects:
  - cfg reg: byte lanes gated by WSTRB.
  - Reg0 bit0: on a write of 1, start_pulse=1 for exactly one cycle; the bit reads back 0.
  - Reg0 bits[3:2] are RO and always read {done, network_busy}.
  - Memory window: ext_mem_wen=1 for exactly one cycle and ext_mem_data_in=WDATA; WSTRB ignored.
  - Counter region or unmapped: no side effect, BRESP=SLVERR (2'b10); otherwise OKAY.
- Read FSM, states R_IDLE, R_MEM, R_RESP:
  - ARREADY high only in R_IDLE; address is latched on the handshake.
  - Register or counter read: RVALID one cycle after the handshake, with RDATA registered.
  - Memory read: R_MEM drives ext_mem_addr for one cycle, data is captured, and RVALID follows two cycles after the handshake.
  - RVALID and RDATA hold stable until RREADY; RDATA returns to 0 after the handshake.
  - Unmapped reads: RDATA=0, RRESP=SLVERR.
- ext_mem_addr arbitration: write has priority; a read in R_MEM stalls one cycle if ext_mem_wen fires in the same cycle.
- Reset mid-transaction aborts everything; no response is issued.
- Simultaneous write to cfg reg X and read of X: the read returns the old value.

Test Plan:
- Reset, then read 0x004 and 0x000 with done=1, busy=0 -> RDATA 100 and 0x00000008, both OKAY.
- AW at cycle 0, W at cycle 3 to 0x008 with data 0xAABBCCDD, WSTRB=0b0101 -> reg2=0x00BB00DD; BVALID at cycle 4; BREADY delayed 2 cycles -> BVALID held.
- Write 0x00000001 to 0x000 -> start_pulse high exactly 1 cycle; readback bit0=0.
- reg2=0x12345600; write 0x55 to 0x810 -> ext_mem_addr=0x12345604, one-cycle wen; read 0x810 with ext data 0x77 -> RVALID 2 cycles after AR, RDATA 0x77.
- Read 0x400+4*NUM_OUTPUTS and write 0x404 -> SLVERR on both; counter value unchanged.
- Concurrent AR to 0x404 and AW/W to 0x00C -> both complete; RDATA = spike_counter_out[1]; reg3 updated.

Source files
------------

// File: rtl/axi_cfg_regfile.sv
// AXI4-Lite configuration register file for the SNN accelerator.
// It holds NUM_CFG_REGS read/write config registers and a bank of read-only
// spike counters. It also maps a 256-word window onto external memory: writes
// to the window become a one-cycle write enable, and reads from it are
// registered. The write and read channels run independently of each other.
module axi_cfg_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int NUM_CFG_REGS       = 4,
    parameter int NUM_OUTPUTS        = 10,
    parameter int SIM_TIME_RESET     = 100
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [32*NUM_OUTPUTS-1:0]         spike_counter_out,
    input  logic                              done,
    input  logic                              network_busy,
    input  logic [31:0]                       ext_mem_data_out,
    output logic [32*NUM_CFG_REGS-1:0]        cfg_regs,
    output logic                              start_pulse,
    output logic [31:0]                       ext_mem_addr,
    output logic                              ext_mem_wen,
    output logic [31:0]                       ext_mem_data_in
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Region select from address bits [11:10]
    localparam logic [1:0] REGION_CFG = 2'b00;
    localparam logic [1:0] REGION_CNT = 2'b01;
    localparam logic [1:0] REGION_MEM = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_MEM, R_RESP} rstate_t;

    // Active-high copy of the AXI reset. It is still sampled synchronously.
    logic Local_Reset;
    assign Local_Reset = ~S_AXI_ARESETN;

    // Word index lies inside a bank of n entries
    function automatic logic idx_in_range(input logic [7:0] idx, input int n);
        return ($unsigned(n) > {24'd0, idx});
    endfunction

    wstate_t     wstate, wstate_nx;
    rstate_t     rstate, rstate_nx;
    logic        rst_done;

    logic [31:0] cfg_q [NUM_CFG_REGS];
    logic [31:0] reg2_val;

    logic        aw_held, w_held;
    logic [11:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_hs, w_hs, do_write;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    logic [1:0]  bresp_q;
    logic        start_pulse_q;
    logic        ext_mem_wen_q;
    logic [31:0] ext_mem_data_in_q;
    logic [7:0]  wr_off_q;

    logic        ar_hs;
    logic [7:0]  rd_off_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [31:0] rd_val;
    logic [1:0]  rd_resp;

    logic        unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    // Handshakes. The write takes either the held beat or the live beat, so
    // it can be performed on the same edge that the last beat arrives.
    assign aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs     = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
    assign do_write = (wstate == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
    assign wr_addr  = aw_held ? aw_addr_q : S_AXI_AWADDR[11:0];
    assign wr_data  = w_held ? w_data_q : S_AXI_WDATA[31:0];
    assign wr_strb  = w_held ? w_strb_q : S_AXI_WSTRB[3:0];

    // Write FSM state register, plus the held-beat flags and the ready qualifier.
    // rst_done keeps every READY low while reset is being held.
    always_ff @(posedge S_AXI_ACLK) begin
        if (Local_Reset) begin
            wstate   <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            wstate   <= wstate_nx;
            rst_done <= 1'b1;
            if (do_write) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
        end
    end

    // Capture an address or data beat that arrives before its partner.
    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs) aw_addr_q <= S_AXI_AWADDR[11:0];
        if (w_hs) begin
            w_data_q <= S_AXI_WDATA[31:0];
            w_strb_q <= S_AXI_WSTRB[3:0];
        end
    end

    // Write FSM next-state logic.
    always_comb begin
        wstate_nx = wstate;
        case (wstate)
            W_IDLE:  if (do_write) wstate_nx = W_RESP;
            W_RESP:  if (S_AXI_BREADY) wstate_nx = W_IDLE;
            default: wstate_nx = W_IDLE;
        endcase
    end

    // Write FSM outputs. A channel is ready only while nothing is held on it
    // and no response is pending.
    always_comb begin
        S_AXI_AWREADY = rst_done & (wstate == W_IDLE) & ~aw_held;
        S_AXI_WREADY  = rst_done & (wstate == W_IDLE) & ~w_held;
        S_AXI_BVALID  = (wstate == W_RESP);
    end

    // Write side effects: strobed config update, start pulse, memory write pulse.
    always_ff @(posedge S_AXI_ACLK) begin
        if (Local_Reset) begin
            for (int i = 0; i < NUM_CFG_REGS; i++)
                cfg_q[i] <= (i == 1) ? 32'(SIM_TIME_RESET) : 32'd0;
            bresp_q           <= RESP_OKAY;
            start_pulse_q     <= 1'b0;
            ext_mem_wen_q     <= 1'b0;
            ext_mem_data_in_q <= 32'd0;
            wr_off_q          <= 8'd0;
        end else begin
            start_pulse_q <= 1'b0;
            ext_mem_wen_q <= 1'b0;
            if (do_write) begin
                bresp_q <= RESP_SLVERR;
                case (wr_addr[11:10])
                    REGION_CFG: begin
                        if (idx_in_range(wr_addr[9:2], NUM_CFG_REGS)) begin
                            bresp_q <= RESP_OKAY;
                            for (int i = 0; i < NUM_CFG_REGS; i++)
                                if (wr_addr[9:2] == 8'(i))
                                    for (int b = 0; b < 4; b++)
                                        if (wr_strb[b]) cfg_q[i][8*b +: 8] <= wr_data[8*b +: 8];
                            if (wr_addr[9:2] == 8'd0 && wr_strb[0] && wr_data[0])
                                start_pulse_q <= 1'b1;
                        end
                    end
                    REGION_MEM: begin
                        bresp_q           <= RESP_OKAY;
                        ext_mem_wen_q     <= 1'b1;
                        ext_mem_data_in_q <= wr_data;
                        wr_off_q          <= wr_addr[9:2];
                    end
                    default: ;
                endcase
            end
            // Start is self-clearing and bits [3:2] are overlaid with live status on reads.
            cfg_q[0][0]   <= 1'b0;
            cfg_q[0][3:2] <= 2'b00;
        end
    end

    // Read FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (Local_Reset) rstate <= R_IDLE;
        else             rstate <= rstate_nx;
    end

    // Read FSM next-state logic. A window read waits in R_MEM while a memory
    // write owns the shared address bus.
    always_comb begin
        rstate_nx = rstate;
        case (rstate)
            R_IDLE: if (ar_hs)
                        rstate_nx = (S_AXI_ARADDR[11:10] == REGION_MEM) ? R_MEM : R_RESP;
            R_MEM:  if (!ext_mem_wen_q) rstate_nx = R_RESP;
            R_RESP: if (S_AXI_RREADY) rstate_nx = R_IDLE;
            default: rstate_nx = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        S_AXI_ARREADY = rst_done & (rstate == R_IDLE);
        S_AXI_RVALID  = (rstate == R_RESP);
    end

    // Read decode for register and counter reads. Window reads return their data later.
    always_comb begin
        rd_val  = 32'd0;
        rd_resp = RESP_SLVERR;
        case (S_AXI_ARADDR[11:10])
            REGION_CFG: if (idx_in_range(S_AXI_ARADDR[9:2], NUM_CFG_REGS)) begin
                rd_resp = RESP_OKAY;
                for (int i = 0; i < NUM_CFG_REGS; i++)
                    if (S_AXI_ARADDR[9:2] == 8'(i)) rd_val = cfg_q[i];
                if (S_AXI_ARADDR[9:2] == 8'd0) rd_val[3:2] = {done, network_busy};
            end
            REGION_CNT: if (idx_in_range(S_AXI_ARADDR[9:2], NUM_OUTPUTS)) begin
                rd_resp = RESP_OKAY;
                for (int i = 0; i < NUM_OUTPUTS; i++)
                    if (S_AXI_ARADDR[9:2] == 8'(i)) rd_val = spike_counter_out[32*i +: 32];
            end
            REGION_MEM: rd_resp = RESP_OKAY;
            default: ;
        endcase
    end

    // Read data path. Data and response are held until RREADY, then cleared.
    always_ff @(posedge S_AXI_ACLK) begin
        if (Local_Reset) begin
            rdata_q  <= 32'd0;
            rresp_q  <= RESP_OKAY;
            rd_off_q <= 8'd0;
        end else begin
            case (rstate)
                R_IDLE: if (ar_hs) begin
                    rd_off_q <= S_AXI_ARADDR[9:2];
                    rdata_q  <= rd_val;
                    rresp_q  <= rd_resp;
                end
                R_MEM: if (!ext_mem_wen_q) begin
                    rdata_q <= ext_mem_data_out;
                    rresp_q <= RESP_OKAY;
                end
                R_RESP: if (S_AXI_RREADY) begin
                    rdata_q <= 32'd0;
                    rresp_q <= RESP_OKAY;
                end
                default: ;
            endcase
        end
    end

    // Memory page base comes from cfg reg 2. Write offset has priority on the bus.
    always_comb begin
        reg2_val = 32'd0;
        for (int i = 0; i < NUM_CFG_REGS; i++)
            if (i == 2) reg2_val = cfg_q[i];
        ext_mem_addr = {reg2_val[31:8], ext_mem_wen_q ? wr_off_q : rd_off_q};
    end

    // Flatten the config registers onto the output bus.
    always_comb begin
        cfg_regs = '0;
        for (int i = 0; i < NUM_CFG_REGS; i++)
            cfg_regs[32*i +: 32] = cfg_q[i];
    end

    assign S_AXI_BRESP     = bresp_q;
    assign S_AXI_RDATA     = rdata_q;
    assign S_AXI_RRESP     = rresp_q;
    assign start_pulse     = start_pulse_q;
    assign ext_mem_wen     = ext_mem_wen_q;
    assign ext_mem_data_in = ext_mem_data_in_q;

endmodule

// File: tb/tb_axi_cfg_regfile.sv
// Directed bench for axi_cfg_regfile: a vector table of single transactions,
// followed by hand-written multi-cycle sequences.
module tb_axi_cfg_regfile;

    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESETN;
    logic [11:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [11:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [319:0] spike_counter_out;
    logic        done;
    logic        network_busy;
    logic [31:0] ext_mem_data_out;
    logic [127:0] cfg_regs;
    logic        start_pulse;
    logic [31:0] ext_mem_addr;
    logic        ext_mem_wen;
    logic [31:0] ext_mem_data_in;

    int total = 0;
    int bad   = 0;

    axi_cfg_regfile dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .spike_counter_out(spike_counter_out), .done(done), .network_busy(network_busy),
        .ext_mem_data_out(ext_mem_data_out), .cfg_regs(cfg_regs), .start_pulse(start_pulse),
        .ext_mem_addr(ext_mem_addr), .ext_mem_wen(ext_mem_wen), .ext_mem_data_in(ext_mem_data_in)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    // Full write with AW and W presented together; waits for BVALID with a bound.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit awd, wd, a_now, w_now;
        int n;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        awd = 0; wd = 0; n = 0;
        while (!(awd && wd) && n < 20) begin
            a_now = S_AXI_AWVALID && S_AXI_AWREADY;
            w_now = S_AXI_WVALID && S_AXI_WREADY;
            tick(); n++;
            if (a_now) begin awd = 1; S_AXI_AWVALID = 1'b0; end
            if (w_now) begin wd = 1; S_AXI_WVALID = 1'b0; end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
        check("wr_bvalid_seen", {31'd0, S_AXI_BVALID}, 32'd1);
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    // Full read; returns data, response and cycles from AR handshake to RVALID.
    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        int n;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; n = 0;
        while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        lat = 1;
        while (!S_AXI_RVALID && lat < 20) begin tick(); lat++; end
        check("rd_rvalid_seen", {31'd0, S_AXI_RVALID}, 32'd1);
        d = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat;

        S_AXI_ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        done = 1'b1; network_busy = 1'b0; ext_mem_data_out = 32'd0;
        for (int i = 0; i < 10; i++) spike_counter_out[32*i +: 32] = 32'h1000 + 32'(i);

        tbl[0]  = '{0, 12'h004, 32'h0,        4'h0, 32'd100,      2'b00};
        tbl[1]  = '{0, 12'h000, 32'h0,        4'h0, 32'h00000008, 2'b00};
        tbl[2]  = '{1, 12'h00C, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
        tbl[3]  = '{0, 12'h00C, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        tbl[4]  = '{1, 12'h00C, 32'h11223344, 4'hA, 32'h0,        2'b00};
        tbl[5]  = '{0, 12'h00C, 32'h0,        4'h0, 32'h11AD33EF, 2'b00};
        tbl[6]  = '{0, 12'h400, 32'h0,        4'h0, 32'h00001000, 2'b00};
        tbl[7]  = '{0, 12'h424, 32'h0,        4'h0, 32'h00001009, 2'b00};
        tbl[8]  = '{0, 12'h428, 32'h0,        4'h0, 32'h0,        2'b10};
        tbl[9]  = '{1, 12'h404, 32'h12345678, 4'hF, 32'h0,        2'b10};
        tbl[10] = '{0, 12'h404, 32'h0,        4'h0, 32'h00001001, 2'b00};
        tbl[11] = '{0, 12'h010, 32'h0,        4'h0, 32'h0,        2'b10};
        tbl[12] = '{1, 12'h010, 32'h5A5A5A5A, 4'hF, 32'h0,        2'b10};
        tbl[13] = '{0, 12'hC00, 32'h0,        4'h0, 32'h0,        2'b10};
        tbl[14] = '{1, 12'hFFC, 32'h5A5A5A5A, 4'hF, 32'h0,        2'b10};
        tbl[15] = '{0, 12'h007, 32'h0,        4'h0, 32'd100,      2'b00};
        tbl[16] = '{1, 12'h004, 32'h00000032, 4'hF, 32'h0,        2'b00};
        tbl[17] = '{0, 12'h004, 32'h0,        4'h0, 32'h00000032, 2'b00};

        // Reset state
        tick(); tick(); tick();
        check("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        check("rst_wready",  {31'd0, S_AXI_WREADY},  32'd0);
        check("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        check("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
        check("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
        check("rst_rdata",   S_AXI_RDATA, 32'd0);
        check("rst_start",   {31'd0, start_pulse}, 32'd0);
        check("rst_wen",     {31'd0, ext_mem_wen}, 32'd0);
        check("rst_reg0",    cfg_regs[31:0],   32'd0);
        check("rst_reg1",    cfg_regs[63:32],  32'd100);
        check("rst_reg2",    cfg_regs[95:64],  32'd0);
        S_AXI_ARESETN = 1'b1;
        tick();
        check("post_rst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        check("post_rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);

        // Vector table
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, rs);
                check($sformatf("vec%0d_bresp", i), {30'd0, rs}, {30'd0, tbl[i].exp_resp});
            end else begin
                axi_read(tbl[i].addr, rd, rs, lat);
                check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_data);
                check($sformatf("vec%0d_rresp", i), {30'd0, rs}, {30'd0, tbl[i].exp_resp});
                check($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
            end
        end
        check("reg3_port", cfg_regs[127:96], 32'h11AD33EF);

        // AW first, W three cycles later, BREADY withheld for two cycles
        S_AXI_AWADDR = 12'h008; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        check("split_awready_low", {31'd0, S_AXI_AWREADY}, 32'd0);
        check("split_wready_high", {31'd0, S_AXI_WREADY}, 32'd1);
        check("split_no_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        tick(); tick();
        S_AXI_WDATA = 32'hAABBCCDD; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        check("split_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        tick();
        check("split_bvalid_hold1", {31'd0, S_AXI_BVALID}, 32'd1);
        tick();
        check("split_bvalid_hold2", {31'd0, S_AXI_BVALID}, 32'd1);
        check("split_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("split_bvalid_clr", {31'd0, S_AXI_BVALID}, 32'd0);
        check("split_reg2", cfg_regs[95:64], 32'h00BB00DD);

        // Start pulse: exactly one cycle, bit reads back 0
        S_AXI_AWADDR = 12'h000; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("start_hi", {31'd0, start_pulse}, 32'd1);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("start_lo", {31'd0, start_pulse}, 32'd0);
        axi_read(12'h000, rd, rs, lat);
        check("start_readback", rd, 32'h00000008);

        // Memory window write and read
        axi_write(12'h008, 32'h12345600, 4'hF, rs);
        S_AXI_AWADDR = 12'h810; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'h0;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("mem_wen_hi", {31'd0, ext_mem_wen}, 32'd1);
        check("mem_waddr", ext_mem_addr, 32'h12345604);
        check("mem_wdata", ext_mem_data_in, 32'h55);
        check("mem_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("mem_wen_lo", {31'd0, ext_mem_wen}, 32'd0);
        ext_mem_data_out = 32'h77;
        axi_read(12'h810, rd, rs, lat);
        check("mem_rdata", rd, 32'h77);
        check("mem_rresp", {30'd0, rs}, 32'd0);
        check("mem_rlat", 32'(lat), 32'd2);

        // Concurrent counter read and cfg write
        S_AXI_AWADDR = 12'h00C; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 12'h404;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("conc_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        check("conc_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        check("conc_rdata", S_AXI_RDATA, 32'h00001001);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        check("conc_rdata_clr", S_AXI_RDATA, 32'd0);
        check("conc_reg3", cfg_regs[127:96], 32'hCAFEF00D);

        // Same-register write and read on one edge: the read sees the old value
        S_AXI_AWADDR = 12'h004; S_AXI_WDATA = 32'h99; S_AXI_ARADDR = 12'h004;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("same_old", S_AXI_RDATA, 32'h32);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(12'h004, rd, rs, lat);
        check("same_new", rd, 32'h99);

        // Window read stalls behind a simultaneous window write
        ext_mem_data_out = 32'h88;
        S_AXI_AWADDR = 12'h810; S_AXI_WDATA = 32'h66; S_AXI_ARADDR = 12'h820;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("arb_wr_addr", ext_mem_addr, 32'h12345604);
        check("arb_rvalid0", {31'd0, S_AXI_RVALID}, 32'd0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("arb_rd_addr", ext_mem_addr, 32'h12345608);
        check("arb_rvalid1", {31'd0, S_AXI_RVALID}, 32'd0);
        tick();
        check("arb_rvalid2", {31'd0, S_AXI_RVALID}, 32'd1);
        check("arb_rdata", S_AXI_RDATA, 32'h88);
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;

        // Reset in the middle of a write aborts it
        S_AXI_AWADDR = 12'h00C; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARESETN = 1'b0;
        tick();
        S_AXI_ARESETN = 1'b1;
        tick();
        check("abort_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        S_AXI_WDATA = 32'h0BAD0BAD; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        tick();
        check("abort_no_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        check("abort_reg3", cfg_regs[127:96], 32'd0);
        check("abort_reg1", cfg_regs[63:32], 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
